// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads an opcode byte, lets the decoder report how
// many inline argument bytes follow, gathers them big-endian, then presents
// the complete instruction until the consumer accepts it. On accept the
// consumer may redirect the PC by a signed offset from the opcode address.
module instr_fetch #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_data,
    input  logic                  mem_valid,
    input  logic [1:0]            argc,
    output logic [7:0]            opcode,
    output logic [15:0]           arg,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_en,
    input  logic [15:0]           branch_off
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        DECODE    = 2'd1,
        FETCH_ARG = 2'd2,
        ISSUE     = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [7:0]            r_opcode;
    logic [15:0]           r_arg;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [1:0]            r_remaining;
    logic                  w_mem_rd;
    logic                  w_instr_valid;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_branch_target;

    // Branch offset brought to PC width: sign-extended when the PC is wider
    // than 16 bits, otherwise truncated (the add wraps modulo 2^ADDR_WIDTH).
    generate
        if (ADDR_WIDTH > 16) begin : g_off_ext
            assign w_off = {{(ADDR_WIDTH-16){branch_off[15]}}, branch_off};
        end else begin : g_off_trunc
            assign w_off = branch_off[ADDR_WIDTH-1:0];
        end
    endgenerate

    assign w_branch_target = r_instr_pc + w_off;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_OP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; mem_valid only matters while a read
    // is outstanding, instr_ready only while an instruction is presented.
    always_comb begin
        w_state_next  = r_state;
        w_mem_rd      = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            FETCH_OP: begin
                w_mem_rd = 1'b1;
                if (mem_valid) begin
                    w_state_next = DECODE;
                end
            end
            DECODE: begin
                w_state_next = (argc == 2'd0) ? ISSUE : FETCH_ARG;
            end
            FETCH_ARG: begin
                w_mem_rd = 1'b1;
                if (mem_valid && (r_remaining == 2'd1)) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_instr_valid = 1'b1;
                if (instr_ready) begin
                    w_state_next = FETCH_OP;
                end
            end
            default: begin
                w_state_next = FETCH_OP;
            end
        endcase
    end

    // Datapath: PC, opcode/argument capture and argument byte countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_opcode    <= 8'h00;
            r_arg       <= 16'h0000;
            r_instr_pc  <= '0;
            r_remaining <= 2'd0;
        end else begin
            case (r_state)
                FETCH_OP: begin
                    if (mem_valid) begin
                        r_opcode   <= mem_data;
                        r_instr_pc <= r_pc;
                        r_pc       <= r_pc + PC_ONE;
                        r_arg      <= 16'h0000;
                    end
                end
                DECODE: begin
                    // argc=3 is treated as a two-byte argument.
                    case (argc)
                        2'd0:    r_remaining <= 2'd0;
                        2'd1:    r_remaining <= 2'd1;
                        default: r_remaining <= 2'd2;
                    endcase
                end
                FETCH_ARG: begin
                    if (mem_valid) begin
                        r_arg       <= {r_arg[7:0], mem_data};
                        r_pc        <= r_pc + PC_ONE;
                        r_remaining <= r_remaining - 2'd1;
                    end
                end
                ISSUE: begin
                    if (instr_ready && branch_en) begin
                        r_pc <= w_branch_target;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // Requests and the valid flag are forced low for as long as reset is held.
    assign mem_rd      = w_mem_rd & ~rst;
    assign instr_valid = w_instr_valid & ~rst;
    assign mem_addr    = r_pc;
    assign opcode      = r_opcode;
    assign arg         = r_arg;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a byte memory with programmable latency,
// a decoder lookup table for argc, and a consumer that accepts instructions
// (optionally branching) and checks them against hand-computed values.
module tb_instr_fetch;

    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_data;
    logic          mem_valid;
    logic [1:0]    argc;
    logic [7:0]    opcode;
    logic [15:0]   arg;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          branch_en;
    logic [15:0]   branch_off;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [1:0] argc_tab [0:255];
    int         lat;
    int         n_checks;
    int         n_bad;

    instr_fetch #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .argc        (argc),
        .opcode      (opcode),
        .arg         (arg),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch_en   (branch_en),
        .branch_off  (branch_off)
    );

    // Decoder stand-in: argument count straight from the opcode.
    assign argc = argc_tab[opcode];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: counts request cycles, answers after lat extra cycles with
    // a one-cycle mem_valid, and checks the address held still meanwhile.
    initial begin
        int            cnt;
        logic [AW-1:0] req_addr;
        cnt       = 0;
        req_addr  = '0;
        mem_valid = 1'b0;
        mem_data  = 8'hEE;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mem_valid = 1'b0;
                mem_data  = 8'hEE;
                cnt       = 0;
            end else begin
                if (mem_valid) begin
                    mem_valid = 1'b0;
                    mem_data  = 8'hEE;
                    cnt       = 0;
                end
                if (mem_rd) begin
                    cnt++;
                    if (cnt == 1) req_addr = mem_addr;
                    if (cnt > lat) begin
                        check_eq("addr_stable", 32'(mem_addr), 32'(req_addr));
                        mem_valid = 1'b1;
                        mem_data  = mem[mem_addr];
                    end
                end
            end
        end
    end

    // Wait for an instruction, check it, optionally stall, then accept it
    // (with or without a branch) and check the next fetch address.
    task automatic get_instr(input logic [7:0] e_op, input logic [15:0] e_arg,
                             input logic [AW-1:0] e_pc, input int e_wait,
                             input logic br, input logic [15:0] off,
                             input int hold, input logic [AW-1:0] e_next);
        int n;
        n = 0;
        while (!instr_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) check_eq("issue_timeout", 32'(instr_valid), 32'd1);
        $display("instr op=%h arg=%h pc=%h waited=%0d", opcode, arg, instr_pc, n);
        check_eq("opcode", 32'(opcode), 32'(e_op));
        check_eq("arg", 32'(arg), 32'(e_arg));
        check_eq("instr_pc", 32'(instr_pc), 32'(e_pc));
        if (e_wait >= 0) check_eq("cycles", 32'(n), 32'(e_wait));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(instr_valid), 32'd1);
            check_eq("hold_rd", 32'(mem_rd), 32'd0);
            check_eq("hold_stable", {opcode, arg, 8'(instr_pc)}, {e_op, e_arg, 8'(e_pc)});
        end
        instr_ready = 1'b1;
        branch_en   = br;
        branch_off  = off;
        @(negedge clk);
        instr_ready = 1'b0;
        branch_en   = 1'b0;
        branch_off  = 16'h0000;
        check_eq("next_addr", 32'(mem_addr), 32'(e_next));
        check_eq("next_rd", 32'(mem_rd), 32'd1);
    endtask

    initial begin
        n_checks    = 0;
        n_bad       = 0;
        lat         = 1;
        rst         = 1'b1;
        instr_ready = 1'b0;
        branch_en   = 1'b0;
        branch_off  = 16'h0000;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) argc_tab[i] = 2'd0;
        argc_tab[8'h10] = 2'd1;
        argc_tab[8'h11] = 2'd2;
        argc_tab[8'hA7] = 2'd2;
        argc_tab[8'h20] = 2'd3;
        mem[12'h000] = 8'h03; mem[12'h001] = 8'h04;
        mem[12'h002] = 8'h10; mem[12'h003] = 8'h7F;
        mem[12'h004] = 8'h11; mem[12'h005] = 8'h12; mem[12'h006] = 8'h34;
        mem[12'h007] = 8'hA7; mem[12'h008] = 8'h00; mem[12'h009] = 8'h09;
        mem[12'h00D] = 8'h10; mem[12'h00E] = 8'h55;
        mem[12'h010] = 8'hA7; mem[12'h011] = 8'hFF; mem[12'h012] = 8'hFD;
        mem[12'h020] = 8'h20; mem[12'h021] = 8'hAB; mem[12'h022] = 8'hCD;
        mem[12'hFFF] = 8'h11;

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_rd", 32'(mem_rd), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_regs", {opcode, arg, 8'(instr_pc)}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("first_rd", 32'(mem_rd), 32'd1);
        check_eq("first_addr", 32'(mem_addr), 32'd0);

        // iconst_0, iconst_1, bipush 7F
        get_instr(8'h03, 16'h0000, 12'h000, 3, 1'b0, 16'h0000, 0, 12'h001);
        get_instr(8'h04, 16'h0000, 12'h001, 3, 1'b0, 16'h0000, 0, 12'h002);
        get_instr(8'h10, 16'h007F, 12'h002, 5, 1'b0, 16'h0000, 0, 12'h004);
        // sipush 1234 with 3-cycle memory, stalled 5 cycles in issue
        lat = 3;
        get_instr(8'h11, 16'h1234, 12'h004, 13, 1'b0, 16'h0000, 5, 12'h007);
        lat = 1;
        // goto +9 to 0x010, then goto -3 to 0x00D
        get_instr(8'hA7, 16'h0009, 12'h007, 7, 1'b1, 16'h0009, 0, 12'h010);
        get_instr(8'hA7, 16'hFFFD, 12'h010, 7, 1'b1, 16'hFFFD, 0, 12'h00D);

        // bipush at 0x00D interrupted by reset while fetching its argument
        repeat (3) @(negedge clk);
        check_eq("in_fetch_arg", {31'd0, mem_rd} | (32'(mem_addr) << 1), (32'h00E << 1) | 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(instr_valid), 32'd0);
        check_eq("midrst_rd", 32'(mem_rd), 32'd0);
        check_eq("midrst_regs", {opcode, arg, 8'(instr_pc)}, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("midrst_valid2", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("after_rst_addr", 32'(mem_addr), 32'd0);
        check_eq("after_rst_rd", 32'(mem_rd), 32'd1);
        check_eq("after_rst_valid", 32'(instr_valid), 32'd0);

        // restart at 0, branch back to 0xFFF; sipush there wraps into 0x000
        get_instr(8'h03, 16'h0000, 12'h000, 3, 1'b1, 16'hFFFF, 0, 12'hFFF);
        get_instr(8'h11, 16'h0304, 12'hFFF, 7, 1'b0, 16'h0000, 0, 12'h002);
        get_instr(8'h10, 16'h007F, 12'h002, 5, 1'b1, 16'h001E, 0, 12'h020);
        // argc=3 behaves as a two-byte argument
        get_instr(8'h20, 16'hABCD, 12'h020, 7, 1'b0, 16'h0000, 0, 12'h023);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
